// File: rtl/add_seq.sv
`default_nettype none
// ============================================================================
// Module  : add_seq
// Brief   : Digit-serial adder/subtractor, one DIGIT-bit slice per clock.
//           Optional macro ADD_SEQ_OVF_EN adds the signed-overflow output Ovf.
// Revision: 1.0 - initial release
// ============================================================================
module add_seq #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
`ifdef ADD_SEQ_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int NSLICE = WIDTH / DIGIT;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NSLICE - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic              carry_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              busy_q;
    logic              done_q;
    logic [WIDTH-1:0]  sum_q;
    logic              cout_q;
`ifdef ADD_SEQ_OVF_EN
    logic              ovf_q;
`endif

    logic [31:0]       w_base;
    logic [DIGIT-1:0]  w_a_slice;
    logic [DIGIT-1:0]  w_b_slice;
    logic [DIGIT-1:0]  w_s_slice;
    logic              w_c_slice;
    logic              w_last;

    assign w_base    = 32'(cnt_q) * 32'(DIGIT);
    assign w_a_slice = a_q[w_base +: DIGIT];
    assign w_b_slice = b_q[w_base +: DIGIT];
    assign {w_c_slice, w_s_slice} = {1'b0, w_a_slice} + {1'b0, w_b_slice}
                                  + {{DIGIT{1'b0}}, carry_q};
    assign w_last    = (cnt_q == C_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef ADD_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        // Subtraction is A + ~B + ~borrow, so the borrow is folded into the carry.
                        a_q     <= A;
                        b_q     <= sub ? ~B : B;
                        carry_q <= Cin ^ sub;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
`ifdef ADD_SEQ_OVF_EN
                        ovf_q   <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    sum_q[w_base +: DIGIT] <= w_s_slice;
                    carry_q <= w_c_slice;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (w_last) begin
                        cnt_q   <= '0;
                        cout_q  <= w_c_slice;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
`ifdef ADD_SEQ_OVF_EN
                        // Carry into the MSB is recovered from the MSB sum bit and its operands.
                        ovf_q   <= w_c_slice ^ (w_s_slice[DIGIT-1] ^ w_a_slice[DIGIT-1]
                                                ^ w_b_slice[DIGIT-1]);
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign Sum  = sum_q;
    assign Cout = cout_q;
`ifdef ADD_SEQ_OVF_EN
    assign Ovf  = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_add_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_add_seq
// Brief   : Self-checking bench for add_seq (16/4 main instance, 32/8 wide).
// Revision: 1.0 - initial release
// ============================================================================
module tb_add_seq;

    localparam int W      = 16;
    localparam int D      = 4;
    localparam int NSLICE = W / D;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, sub, cin;
    logic [W-1:0]  a, b;
    logic          busy, done, cout, ovf;
    logic [W-1:0]  sum;

    logic          start2, sub2, cin2;
    logic [31:0]   a2, b2, sum2;
    logic          busy2, done2, cout2, ovf2;

    always #5 clk = ~clk;

    add_seq #(.WIDTH(W), .DIGIT(D)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .A(a), .B(b), .Cin(cin),
        .busy(busy), .done(done), .Sum(sum), .Cout(cout)
`ifdef ADD_SEQ_OVF_EN
        , .Ovf(ovf)
`endif
    );

    add_seq #(.WIDTH(32), .DIGIT(8)) u_wide (
        .clk(clk), .rst_n(rst_n), .start(start2), .sub(sub2), .A(a2), .B(b2), .Cin(cin2),
        .busy(busy2), .done(done2), .Sum(sum2), .Cout(cout2)
`ifdef ADD_SEQ_OVF_EN
        , .Ovf(ovf2)
`endif
    );

`ifndef ADD_SEQ_OVF_EN
    assign ovf  = 1'b0;
    assign ovf2 = 1'b0;
`endif

    typedef struct {
        logic         sub;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding operation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no done (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sum", 32'(sum), 32'(e.sum));
                chk("cout", 32'(cout), 32'(e.cout));
                chk("done_cycle", cyc, e.cyc);
`ifdef ADD_SEQ_OVF_EN
                chk("ovf", 32'(ovf), 32'(e.ovf));
`endif
            end
        end
    end

    // Called at a negedge; the accepting edge is the next posedge.
    task automatic drive(input logic s, input logic [W-1:0] aa, input logic [W-1:0] bb,
                         input logic c, input logic [W-1:0] es, input logic ec, input logic eo);
        sub = s; a = aa; b = bb; cin = c; start = 1'b1;
        sb.push_back('{es, ec, eo, cyc + NSLICE + 1});
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("timeout_done", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic run_op(input logic s, input logic [W-1:0] aa, input logic [W-1:0] bb,
                          input logic c, input logic [W-1:0] es, input logic ec, input logic eo);
        @(negedge clk);
        drive(s, aa, bb, c, es, ec, eo);
        @(negedge clk);
        start = 1'b0;
        drain();
    endtask

    vec_t vecs[12];

    initial begin
        int n;
        vecs[0]  = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[9]  = '{1'b1, 16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 16'h0FFF, 16'h0001, 1'b1, 16'h1001, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b0, 1'b1};

        rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        start2 = 1'b0; sub2 = 1'b0; cin2 = 1'b0; a2 = '0; b2 = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_wide_busy", 32'(busy2), 32'd0);
        rst_n = 1'b1;

        // Latency and busy profile: busy after accept and 3 RUN edges, done after the 4th.
        @(negedge clk);
        drive(1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        for (int i = 0; i < NSLICE; i++) begin
            @(negedge clk);
            start = 1'b0;
            chk("lat_busy", 32'(busy), 32'd1);
            chk("lat_done_early", 32'(done), 32'd0);
        end
        @(negedge clk);
        chk("lat_busy_end", 32'(busy), 32'd0);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        for (int i = 0; i < 12; i++)
            run_op(vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].cin,
                   vecs[i].sum, vecs[i].cout, vecs[i].ovf);

        // start while busy is ignored; result then holds after done.
        @(negedge clk);
        drive(1'b0, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        sub = 1'b1; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; start = 1'b1;
        chk("ign_busy", 32'(busy), 32'd1);
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (3) @(negedge clk);
        chk("sum_held", 32'(sum), 32'h5556);

        // start held high through the done cycle launches a back-to-back operation.
        @(negedge clk);
        drive(1'b0, 16'h0100, 16'h0200, 1'b0, 16'h0300, 1'b0, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 100);
        chk("b2b_first_done", 32'(done), 32'd1);
        drive(1'b0, 16'hF000, 16'h1000, 1'b0, 16'h0000, 1'b1, 1'b0);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", 32'(busy), 32'd1);
        drain();

        // Asynchronous reset mid-operation.
        run_op(1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        @(negedge clk);
        sub = 1'b0; a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("partial_sum", 32'(sum), 32'h0033);
        chk("partial_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_sum", 32'(sum), 32'd0);
        chk("arst_cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1'b0, 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0);

        // Wide instance: 32 bits in 8-bit slices, done after edge 5.
        @(negedge clk);
        a2 = 32'h89ABCDEF; b2 = 32'h76543211; sub2 = 1'b0; cin2 = 1'b0; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        chk("wide_busy", 32'(busy2), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("wide_done_early", 32'(done2), 32'd0);
        end
        @(negedge clk);
        chk("wide_done", 32'(done2), 32'd1);
        chk("wide_sum", sum2, 32'h00000000);
        chk("wide_cout", 32'(cout2), 32'd1);
        chk("wide_ovf", 32'(ovf2), 32'd0);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
